chs_config_sequencer: RTL

Sequencing controller for the cool/heat-system (CHS) configuration datapath. On a start request it loads the 8-bit CHS configuration into the external shift register and then shifts it out bit by bit. While shifting it counts the ones in the serial stream and reports the population count, even parity and a parity check against an expected value. It sits between the CHS control logic, which issues start/abort, and the configuration shift register, which it drives through `sh_load`, `sh_shift` and `sh_out`.

---
 rtl/chs_pkg.sv | 18 +
 rtl/chs_bit_accumulator.sv | 38 +++
 rtl/chs_config_sequencer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/chs_pkg.sv
// Shared types and sizing helpers for the CHS configuration sequencer.
package chs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } chs_state_e;

  localparam int CHS_CONF_W = 8;

  // Bits needed to hold a ones count in the range 0..w inclusive.
  function automatic int chs_cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/chs_bit_accumulator.sv
// Popcount counter for the serial configuration stream: synchronous clear,
// increments by one whenever the enabled input bit is set.
module chs_bit_accumulator #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic          bit_in,
  output logic [CW-1:0] count
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = {CW{1'b0}};
    end else if (en) begin
      count_d = count_q + CW'(bit_in);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= {CW{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/chs_config_sequencer.sv
// Loads the CHS configuration into the external shift register, shifts it out
// and reports popcount / parity of the serial stream at the end of each frame.
module chs_config_sequencer
  import chs_pkg::*;
#(
  parameter int WIDTH = CHS_CONF_W,
  parameter int CW    = chs_cnt_w(WIDTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          exp_even,
  input  logic          sh_out,
  output logic          sh_load,
  output logic          sh_shift,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] ones_count,
  output logic          is_even,
  output logic          parity_ok
);

  localparam int            IW       = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  chs_state_e    state_q, state_d;
  logic [IW-1:0] bit_idx_q, bit_idx_d;
  logic          exp_q, exp_d;
  logic [CW-1:0] ones_q, ones_d;
  logic          even_q, even_d;
  logic          pok_q, pok_d;
  logic          sh_load_q, sh_shift_q, busy_q, done_q;

  logic [CW-1:0] acc_cnt_s;
  logic [CW-1:0] final_cnt_s;

  chs_bit_accumulator #(
    .CW (CW)
  ) u_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state_q == ST_LOAD),
    .en     (state_q == ST_SHIFT),
    .bit_in (sh_out),
    .count  (acc_cnt_s)
  );

  // The last serial bit is added on the same edge that enters DONE.
  assign final_cnt_s = acc_cnt_s + CW'(sh_out);

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    exp_d     = exp_q;
    ones_d    = ones_q;
    even_d    = even_q;
    pok_d     = pok_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d = ST_LOAD;
          exp_d   = exp_even;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        bit_idx_d = {IW{1'b0}};
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bit_idx_d = bit_idx_q + IW'(1);
        if (abort) begin
          state_d = ST_IDLE;
        end else if (bit_idx_q == LAST_IDX) begin
          state_d = ST_DONE;
          ones_d  = final_cnt_s;
          even_d  = ~final_cnt_s[0];
          pok_d   = (~final_cnt_s[0]) == exp_q;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        // Abort here only suppresses a back-to-back restart.
        if (start && !abort) begin
          state_d = ST_LOAD;
          exp_d   = exp_even;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bit_idx_q  <= {IW{1'b0}};
      exp_q      <= 1'b0;
      ones_q     <= {CW{1'b0}};
      even_q     <= 1'b1;
      pok_q      <= 1'b0;
      sh_load_q  <= 1'b0;
      sh_shift_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      exp_q      <= exp_d;
      ones_q     <= ones_d;
      even_q     <= even_d;
      pok_q      <= pok_d;
      sh_load_q  <= (state_d == ST_LOAD);
      sh_shift_q <= (state_d == ST_SHIFT);
      busy_q     <= (state_d == ST_LOAD) || (state_d == ST_SHIFT);
      done_q     <= (state_d == ST_DONE);
    end
  end

  assign sh_load    = sh_load_q;
  assign sh_shift   = sh_shift_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign ones_count = ones_q;
  assign is_even    = even_q;
  assign parity_ok  = pok_q;

endmodule
